// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// Holds the FSM state encoding, the source-tag prefix and the grant index width.
package uart_arb_pkg;

  localparam int GID_W = 4;
  localparam logic [3:0] TAG_PREFIX = 4'hA;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    TAG    = 3'd1,
    SEND   = 3'd2,
    START  = 3'd3,
    SETTLE = 3'd4,
    DRAIN  = 3'd5
  } arb_state_t;

  // Increment that sticks at lim instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v, input logic [7:0] lim);
    return (v == lim) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the first requester at or after (i_ptr+1),
// wrapping modulo NUM_REQ, wins.
module rr_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [GID_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [GID_W-1:0]   o_idx,
  output logic               o_any
);

  always_comb begin
    int   c;
    logic found;
    c       = 0;
    found   = 1'b0;
    o_grant = '0;
    o_idx   = '0;
    // i_ptr is always a valid index, so one subtraction is enough to wrap
    for (int k = 1; k <= NUM_REQ; k++) begin
      c = int'(i_ptr) + k;
      if (c >= NUM_REQ) c = c - NUM_REQ;
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!found && (c == j) && i_req[j]) begin
          found      = 1'b1;
          o_grant[j] = 1'b1;
          o_idx      = GID_W'(j);
        end
      end
    end
    o_any = found;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin sharing of one async transmitter between NUM_REQ
// byte streams. Define UART_TX_SRC_TAG_EN to prefix every grant with a source-tag byte.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int MAX_BURST   = 64,
  parameter int STALL_LIMIT = 65535
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*8-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  input  logic                 tx_busy,
  output logic [3:0]           grant_id,
  output logic                 grant_active,
  output logic                 pkt_done,
  output logic                 pkt_trunc
);

  localparam logic [7:0]  BURST_MAX  = 8'(MAX_BURST);
  localparam logic [15:0] STALL_LAST = 16'(STALL_LIMIT - 1);

  arb_state_t       r_state;
  logic [GID_W-1:0] r_ptr;
  logic [GID_W-1:0] r_grant_id;
  logic [NUM_REQ-1:0] r_grant_oh;
  logic             r_grant_active;
  logic             r_last;
  logic [7:0]       r_byte_cnt;
  logic [15:0]      r_stall_cnt;
  logic             r_tx_start;
  logic [7:0]       r_tx_data;
  logic             r_pkt_done;
  logic             r_pkt_trunc;

  logic [NUM_REQ-1:0] w_grant;
  logic [GID_W-1:0]   w_idx;
  logic               w_any;
  logic [7:0]         w_bytes [NUM_REQ];
  logic               w_sel_valid;
  logic               w_sel_last;
  logic [7:0]         w_sel_data;
  logic               w_send_open;
  logic               w_accept;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .i_req   (req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign w_bytes[gi]   = req_data[8*gi +: 8];
      assign req_ready[gi] = w_send_open & r_grant_oh[gi];
    end
  endgenerate

  // One-hot mux of the granted requester's stream
  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_last  = 1'b0;
    w_sel_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_sel_valid = w_sel_valid | (req_valid[i] & r_grant_oh[i]);
      w_sel_last  = w_sel_last  | (req_last[i]  & r_grant_oh[i]);
      w_sel_data  = w_sel_data  | (w_bytes[i] & {8{r_grant_oh[i]}});
    end
  end

  assign w_send_open = !rst && (r_state == SEND) && !tx_busy;
  assign w_accept    = w_send_open && w_sel_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= IDLE;
      r_ptr          <= GID_W'(NUM_REQ - 1);
      r_grant_id     <= '0;
      r_grant_oh     <= '0;
      r_grant_active <= 1'b0;
      r_last         <= 1'b0;
      r_byte_cnt     <= '0;
      r_stall_cnt    <= '0;
      r_tx_start     <= 1'b0;
      r_tx_data      <= '0;
      r_pkt_done     <= 1'b0;
      r_pkt_trunc    <= 1'b0;
    end else begin
      r_pkt_done  <= 1'b0;
      r_pkt_trunc <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_grant_id     <= w_idx;
            r_grant_oh     <= w_grant;
            r_ptr          <= w_idx;
            r_grant_active <= 1'b1;
            r_byte_cnt     <= '0;
            r_stall_cnt    <= '0;
            r_last         <= 1'b0;
`ifdef UART_TX_SRC_TAG_EN
            r_state        <= TAG;
`else
            r_state        <= SEND;
`endif
          end
        end
`ifdef UART_TX_SRC_TAG_EN
        TAG: begin
          // The header does not count towards the burst limit
          if (!tx_busy) begin
            r_tx_data  <= {TAG_PREFIX, r_grant_id};
            r_tx_start <= 1'b1;
            r_last     <= 1'b0;
            r_state    <= START;
          end
        end
`endif
        SEND: begin
          if (w_accept) begin
            r_tx_data  <= w_sel_data;
            r_tx_start <= 1'b1;
            r_last     <= w_sel_last;
            r_byte_cnt <= sat_inc8(r_byte_cnt, BURST_MAX);
            r_state    <= START;
          end else if (!w_sel_valid) begin
            if (r_stall_cnt == STALL_LAST) begin
              r_grant_active <= 1'b0;
              r_pkt_done     <= 1'b1;
              r_pkt_trunc    <= 1'b1;
              r_state        <= IDLE;
            end else if (r_stall_cnt != 16'hFFFF) begin
              r_stall_cnt <= r_stall_cnt + 16'd1;
            end
          end
        end
        START: begin
          r_tx_start <= 1'b0;
          r_state    <= SETTLE;
        end
        SETTLE: begin
          // Transmitter busy becomes visible from this cycle on
          r_state <= DRAIN;
        end
        DRAIN: begin
          if (!tx_busy) begin
            if (r_last || (r_byte_cnt == BURST_MAX)) begin
              r_grant_active <= 1'b0;
              r_pkt_done     <= 1'b1;
              r_pkt_trunc    <= !r_last;
              r_state        <= IDLE;
            end else begin
              r_stall_cnt <= '0;
              r_state     <= SEND;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign tx_start     = r_tx_start;
  assign tx_data      = r_tx_data;
  assign grant_id     = r_grant_id;
  assign grant_active = r_grant_active;
  assign pkt_done     = r_pkt_done;
  assign pkt_trunc    = r_pkt_trunc;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized and directed bench for uart_tx_arbiter against a queue-based
// model of packet-granular round-robin arbitration.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ     = 4;
  localparam int MAX_BURST   = 4;
  localparam int STALL_LIMIT = 10;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ*8-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 tx_start;
  logic [7:0]           tx_data;
  logic                 tx_busy = 1'b0;
  logic [3:0]           grant_id;
  logic                 grant_active;
  logic                 pkt_done;
  logic                 pkt_trunc;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ(NUM_REQ), .MAX_BURST(MAX_BURST), .STALL_LIMIT(STALL_LIMIT)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
    .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
    .grant_id(grant_id), .grant_active(grant_active),
    .pkt_done(pkt_done), .pkt_trunc(pkt_trunc)
  );

  // Transmitter stand-in: busy rises the edge after start and stays high busy_len cycles.
  int busy_len = 3;
  int busy_cnt = 0;
  always @(posedge clk) begin
    if (tx_busy) begin
      if (busy_cnt <= 1) tx_busy <= 1'b0;
      busy_cnt <= busy_cnt - 1;
    end else if (tx_start) begin
      tx_busy  <= 1'b1;
      busy_cnt <= busy_len;
    end
  end

  typedef struct packed { logic last; logic [7:0] data; } ent_t;
  typedef struct packed { logic [3:0] id; logic [7:0] data; } txb_t;
  typedef struct packed { logic [3:0] id; logic [1:0] kind; } rel_t; // kind 0 normal, 1 burst, 2 stall

  ent_t rq [NUM_REQ][$];
  txb_t exp_tx[$];
  rel_t exp_rel[$];
  logic [3:0] rel_log[$];
  logic       trunc_log[$];
  logic [7:0] tx_log[$];

  int   m_ptr = NUM_REQ - 1;
  int   n_checks = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   busy_fall_cyc = -1;
  int   rst_cyc = 0;
  logic prev_start = 1'b0;
  logic prev_busy = 1'b0;
  bit   chk_after_rst = 1'b0;
  bit   long_busy = 1'b0;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: replay arbitration rules over the queued bytes to get the serial stream and releases.
  task automatic plan();
    ent_t q [NUM_REQ][$];
    int   ptr;
    int   w;
    int   cnt;
    ent_t e;
    txb_t t;
    rel_t r;
    for (int i = 0; i < NUM_REQ; i++) q[i] = rq[i];
    ptr = m_ptr;
    forever begin
      w = -1;
      for (int k = 1; k <= NUM_REQ; k++) begin
        int c;
        c = (ptr + k) % NUM_REQ;
        if (w < 0 && q[c].size() > 0) w = c;
      end
      if (w < 0) break;
      ptr = w;
      cnt = 0;
`ifdef UART_TX_SRC_TAG_EN
      t.id = 4'(w); t.data = {4'hA, 4'(w)};
      exp_tx.push_back(t);
`endif
      forever begin
        if (q[w].size() == 0) begin r.kind = 2'd2; break; end
        e = q[w].pop_front();
        t.id = 4'(w); t.data = e.data;
        exp_tx.push_back(t);
        cnt++;
        if (e.last) begin r.kind = 2'd0; break; end
        if (cnt == MAX_BURST) begin r.kind = 2'd1; break; end
      end
      r.id = 4'(w);
      exp_rel.push_back(r);
    end
    m_ptr = ptr;
  endtask

  task automatic drive();
    for (int i = 0; i < NUM_REQ; i++) begin
      req_valid[i] = (rq[i].size() > 0);
      req_data[8*i +: 8] = (rq[i].size() > 0) ? rq[i][0].data : 8'h00;
      req_last[i] = (rq[i].size() > 0) ? rq[i][0].last : 1'b0;
    end
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < NUM_REQ; i++) if (rq[i].size() > 0) return 1'b0;
    return 1'b1;
  endfunction

  // One clock: observe at negedge, update requester streams just after posedge.
  task automatic step();
    logic [NUM_REQ-1:0] acc;
    txb_t t;
    rel_t r;
    @(negedge clk);
    cyc++;
    if (prev_busy && !tx_busy) busy_fall_cyc = cyc;
    prev_busy = tx_busy;
    if (pkt_trunc) check("trunc_has_done", pkt_done, 1);
    if (tx_start) begin
      $display("[%0d] tx byte 0x%02h grant %0d", cyc, tx_data, grant_id);
      check("start_busy_low", tx_busy, 0);
      check("start_one_cycle", prev_start, 0);
      if (chk_after_rst) begin
        check("start_after_busy_fall", busy_fall_cyc > rst_cyc, 1);
        chk_after_rst = 1'b0;
      end
      tx_log.push_back(tx_data);
      check("tx_expected", exp_tx.size() > 0, 1);
      if (exp_tx.size() > 0) begin
        t = exp_tx.pop_front();
        check("tx_data", tx_data, t.data);
        check("tx_grant_id", grant_id, t.id);
      end
    end
    prev_start = tx_start;
    if (pkt_done) begin
      $display("[%0d] release grant %0d trunc %0d", cyc, grant_id, pkt_trunc);
      rel_log.push_back(grant_id);
      trunc_log.push_back(pkt_trunc);
      check("rel_expected", exp_rel.size() > 0, 1);
      if (exp_rel.size() > 0) begin
        r = exp_rel.pop_front();
        check("rel_grant_id", grant_id, r.id);
        check("rel_trunc", pkt_trunc, r.kind != 2'd0);
        check("rel_active_low", grant_active, 0);
        if (r.kind == 2'd2) check("stall_latency", cyc - busy_fall_cyc, STALL_LIMIT + 1);
      end
    end
    acc = req_valid & req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < NUM_REQ; i++) if (acc[i]) void'(rq[i].pop_front());
    busy_len = long_busy ? 20 : $urandom_range(2, 6);
    drive();
  endtask

  task automatic run_phase(string name);
    int c;
    c = 0;
    drive();
    while (c < 4000 && !(exp_tx.size() == 0 && exp_rel.size() == 0 && !grant_active && all_empty())) begin
      step();
      c++;
    end
    check({name, "_tx_left"}, exp_tx.size(), 0);
    check({name, "_rel_left"}, exp_rel.size(), 0);
  endtask

  task automatic push(int r, logic [7:0] d, logic l);
    ent_t e;
    e.data = d; e.last = l;
    rq[r].push_back(e);
  endtask

  function automatic void clear_logs();
    rel_log.delete(); trunc_log.delete(); tx_log.delete();
  endfunction

  initial begin
    int exp_order[4];
    exp_order = '{0, 2, 0, 2};
    rst = 1'b1;
    req_valid = '0; req_data = '0; req_last = '0;

    // Reset with requesters 0 and 2 already presenting one-byte packets
    push(0, 8'hA0, 1'b1); push(0, 8'hA1, 1'b1);
    push(2, 8'hC0, 1'b1); push(2, 8'hC1, 1'b1);
    drive();
    repeat (3) step();
    check("rst_tx_start", tx_start, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_grant_id", grant_id, 0);
    check("rst_grant_active", grant_active, 0);
    check("rst_pkt_done", pkt_done, 0);
    check("rst_pkt_trunc", pkt_trunc, 0);
    check("rst_req_ready", req_ready, 0);
    m_ptr = NUM_REQ - 1;
    plan();
    clear_logs();
    rst = 1'b0;
    run_phase("rr");
    check("rr_order_n", rel_log.size(), 4);
    for (int i = 0; i < 4; i++) if (i < rel_log.size()) check("rr_order", rel_log[i], exp_order[i]);

    // Two-byte packet on requester 0
    clear_logs();
    push(0, 8'h55, 1'b0); push(0, 8'h3C, 1'b1);
    plan();
    run_phase("pkt2");
    check("pkt2_rel_n", rel_log.size(), 1);
    if (trunc_log.size() > 0) check("pkt2_trunc", trunc_log[0], 0);

    // Six bytes without last: burst release after four, remaining two then stall
    clear_logs();
    for (int i = 0; i < 6; i++) push(1, 8'(8'h10 + i), 1'b0);
    plan();
    run_phase("burst");
    check("burst_rel_n", rel_log.size(), 2);
    for (int i = 0; i < 2; i++) if (i < trunc_log.size()) check("burst_trunc", trunc_log[i], 1);

    // Last byte landing exactly on the burst limit is a normal release
    clear_logs();
    for (int i = 0; i < 4; i++) push(2, 8'(8'h20 + i), i == 3);
    plan();
    run_phase("edge");
    check("edge_rel_n", rel_log.size(), 1);
    if (trunc_log.size() > 0) check("edge_trunc", trunc_log[0], 0);

    // Stall after one byte on requester 3
    clear_logs();
    push(3, 8'h77, 1'b0);
    plan();
    run_phase("stall");
    check("stall_rel_n", rel_log.size(), 1);
    if (trunc_log.size() > 0) check("stall_trunc", trunc_log[0], 1);

    // Source tag stream for requester 2
    clear_logs();
    push(2, 8'h41, 1'b1);
    plan();
    run_phase("tag");
`ifdef UART_TX_SRC_TAG_EN
    check("tag_n", tx_log.size(), 2);
    if (tx_log.size() > 1) begin
      check("tag_hdr", tx_log[0], 8'hA2);
      check("tag_payload", tx_log[1], 8'h41);
    end
`else
    check("tag_n", tx_log.size(), 1);
    if (tx_log.size() > 0) check("tag_payload", tx_log[0], 8'h41);
`endif

    // Reset while draining a byte through a slow transmitter
    clear_logs();
    long_busy = 1'b1;
    busy_len = 20;
    push(3, 8'h11, 1'b0); push(3, 8'h22, 1'b1);
    plan();
    drive();
    for (int c = 0; c < 200 && !tx_start; c++) step();
    check("rd_started", tx_start, 1);
    step();
    step();
    check("rd_busy_env", tx_busy, 1);
    rst = 1'b1;
    step();
    check("rd_tx_start", tx_start, 0);
    check("rd_grant_active", grant_active, 0);
    check("rd_grant_id", grant_id, 0);
    rst = 1'b0;
    long_busy = 1'b0;
    rst_cyc = cyc;
    chk_after_rst = 1'b1;
    exp_tx.delete();
    exp_rel.delete();
    m_ptr = NUM_REQ - 1;
    plan();
    run_phase("rstdrain");
    check("rd_after_start_seen", chk_after_rst, 0);

    // Randomized traffic on all requesters
    for (int round = 0; round < 4; round++) begin
      clear_logs();
      for (int r = 0; r < NUM_REQ; r++) begin
        int npk;
        npk = $urandom_range(0, 3);
        for (int p = 0; p < npk; p++) begin
          int len;
          len = $urandom_range(1, 6);
          for (int b = 0; b < len; b++)
            push(r, 8'($urandom), (b == len - 1) && ($urandom_range(0, 7) != 0));
        end
      end
      plan();
      run_phase("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
